// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - parallel-to-serial bridge between two fully-connected layers
//
// Captures the NUM_VALUES-wide vector of a hidden layer on the rising edge of
// "all neurons valid". It then streams the elements, element 0 first, one per
// accepted beat (VALID_OUT & READY_IN). The overflow flag sampled at capture
// travels with the vector.
//
// Optional feature macro: LAYER_SERIALIZER_DBUF_EN
//   defined   : two ping-pong banks. A vector can be captured while another streams.
//   undefined : one bank. A capture while streaming is dropped. The exception is
//               a capture in the cycle of the last transfer.
//
// Ports:
//   CLK           in   clock, rising edge
//   RSTN          in   asynchronous active-low reset
//   VALUES_IN     in   upstream vector, element i at [i*WIDTH +: WIDTH]
//   VALIDS_IN     in   per-neuron valids
//   OVERFLOW_IN   in   upstream overflow, sampled at capture
//   VALUE_OUT     out  current element (signed fixed point, passed through)
//   VALID_OUT     out  VALUE_OUT is valid
//   READY_IN      in   downstream ready
//   LAST_OUT      out  high with element NUM_VALUES-1
//   OVERFLOW_OUT  out  overflow flag of the vector being streamed
//   BUSY          out  a vector is held (streaming or pending)
//   DROP          out  one-cycle pulse: arriving vector found no free bank

module layer_serializer #(
    parameter int NUM_VALUES = 4,
    parameter int WIDTH      = 8,
    parameter int FRAC_BITS  = 3
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic [NUM_VALUES*WIDTH-1:0]   VALUES_IN,
    input  logic [NUM_VALUES-1:0]         VALIDS_IN,
    input  logic                          OVERFLOW_IN,
    output logic [WIDTH-1:0]              VALUE_OUT,
    output logic                          VALID_OUT,
    input  logic                          READY_IN,
    output logic                          LAST_OUT,
    output logic                          OVERFLOW_OUT,
    output logic                          BUSY,
    output logic                          DROP
);

    localparam int IDXW = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_VALUES - 1);

`ifdef LAYER_SERIALIZER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    // The binary point must lie inside the word. Values are never re-scaled here.
    if (FRAC_BITS > WIDTH) begin : g_frac_out_of_range
    end

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [IDXW-1:0]               idx_q, idx_d;
    logic                          all_valid_q, all_valid_d;
    // Read and write bank pointers. Both stay at 0 in the single-bank build.
    logic                          rd_q, rd_d;
    logic                          wr_q, wr_d;
    logic [1:0]                    full_q, full_d;
    logic [1:0]                    ovf_q, ovf_d;
    logic [NUM_VALUES*WIDTH-1:0]   bank_q [2];
    logic [NUM_VALUES*WIDTH-1:0]   bank_d [2];

    logic [WIDTH-1:0]              value_out_q, value_out_d;
    logic                          valid_out_q, valid_out_d;
    logic                          last_out_q, last_out_d;
    logic                          overflow_out_q, overflow_out_d;
    logic                          busy_q, busy_d;
    logic                          drop_q, drop_d;

    logic                          capture;
    logic                          accept;
    logic                          xfer;
    logic                          last_xfer;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        full_d         = full_q;
        ovf_d          = ovf_q;
        bank_d         = bank_q;
        all_valid_d    = &VALIDS_IN;

        capture   = all_valid_d & ~all_valid_q;
        xfer      = valid_out_q & READY_IN;
        last_xfer = xfer && (idx_q == LAST_IDX);

        // Free the bank before looking at the capture. A vector that arrives
        // in the cycle of the last transfer can then reuse that bank.
        if (xfer) begin
            if (last_xfer) begin
                full_d[rd_q] = 1'b0;
                rd_d         = DBUF ? ~rd_q : 1'b0;
                idx_d        = '0;
            end else begin
                idx_d = IDXW'(idx_q + 1'b1);
            end
        end

        accept = capture & ~full_d[wr_q];
        if (accept) begin
            bank_d[wr_q] = VALUES_IN;
            ovf_d[wr_q]  = OVERFLOW_IN;
            full_d[wr_q] = 1'b1;
            wr_d         = DBUF ? ~wr_q : 1'b0;
        end
        drop_d = capture & ~accept;

        // Stream whenever the bank under the read pointer holds a vector.
        // This covers the start from IDLE and the hand-over to a pending bank.
        state_d = full_d[rd_d] ? S_STREAM : S_IDLE;
        if (state_d == S_IDLE) begin
            idx_d = '0;
        end

        // The outputs are registered from next-state values. Element 0 of a
        // newly captured vector is therefore visible in the cycle after capture.
        valid_out_d    = (state_d == S_STREAM);
        value_out_d    = '0;
        last_out_d     = 1'b0;
        overflow_out_d = 1'b0;
        if (state_d == S_STREAM) begin
            value_out_d    = bank_d[rd_d][idx_d*WIDTH +: WIDTH];
            last_out_d     = (idx_d == LAST_IDX);
            overflow_out_d = ovf_d[rd_d];
        end
        busy_d = (state_d == S_STREAM) | (|full_d);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            all_valid_q    <= 1'b0;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            full_q         <= '0;
            ovf_q          <= '0;
            bank_q         <= '{default: '0};
            value_out_q    <= '0;
            valid_out_q    <= 1'b0;
            last_out_q     <= 1'b0;
            overflow_out_q <= 1'b0;
            busy_q         <= 1'b0;
            drop_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            all_valid_q    <= all_valid_d;
            rd_q           <= rd_d;
            wr_q           <= wr_d;
            full_q         <= full_d;
            ovf_q          <= ovf_d;
            bank_q         <= bank_d;
            value_out_q    <= value_out_d;
            valid_out_q    <= valid_out_d;
            last_out_q     <= last_out_d;
            overflow_out_q <= overflow_out_d;
            busy_q         <= busy_d;
            drop_q         <= drop_d;
        end
    end

    assign VALUE_OUT    = value_out_q;
    assign VALID_OUT    = valid_out_q;
    assign LAST_OUT     = last_out_q;
    assign OVERFLOW_OUT = overflow_out_q;
    assign BUSY         = busy_q;
    assign DROP         = drop_q;

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - directed self-checking bench for layer_serializer

module tb_layer_serializer;

    logic        CLK;
    logic        RSTN;
    logic [31:0] VALUES_IN;
    logic [3:0]  VALIDS_IN;
    logic        OVERFLOW_IN;
    logic [7:0]  VALUE_OUT;
    logic        VALID_OUT;
    logic        READY_IN;
    logic        LAST_OUT;
    logic        OVERFLOW_OUT;
    logic        BUSY;
    logic        DROP;

    int n_cmp;
    int n_mis;

    // Vector A = {4,-3,2,1}: element 0 is 1.
    localparam logic [31:0] VEC_A = {8'd4, 8'hFD, 8'd2, 8'd1};
    // Vector B = {8,7,6,5}: element 0 is 5.
    localparam logic [31:0] VEC_B = {8'd8, 8'd7, 8'd6, 8'd5};
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];

    layer_serializer #(.NUM_VALUES(4), .WIDTH(8), .FRAC_BITS(3)) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .VALUES_IN    (VALUES_IN),
        .VALIDS_IN    (VALIDS_IN),
        .OVERFLOW_IN  (OVERFLOW_IN),
        .VALUE_OUT    (VALUE_OUT),
        .VALID_OUT    (VALID_OUT),
        .READY_IN     (READY_IN),
        .LAST_OUT     (LAST_OUT),
        .OVERFLOW_OUT (OVERFLOW_OUT),
        .BUSY         (BUSY),
        .DROP         (DROP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        VALUES_IN = '0;
        VALIDS_IN = '0;
        OVERFLOW_IN = 1'b0;
        READY_IN = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({VALID_OUT, VALUE_OUT, LAST_OUT, OVERFLOW_OUT, BUSY, DROP} !== 13'd0) begin
            n_mis++;
            $display("FAIL reset_outputs: got valid=%b value=%h last=%b ovf=%b busy=%b drop=%b, want all 0",
                     VALID_OUT, VALUE_OUT, LAST_OUT, OVERFLOW_OUT, BUSY, DROP);
        end
        RSTN = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (VALID_OUT !== 1'b0 || BUSY !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_release_idle: got valid=%b busy=%b, want 0 0", VALID_OUT, BUSY);
        end
    endtask

    task automatic test_basic_stream();
        VALUES_IN = VEC_A;
        READY_IN = 1'b1;
        VALIDS_IN = 4'hF;
        tick();
        VALIDS_IN = 4'h0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (VALID_OUT !== 1'b1 || VALUE_OUT !== exp_a[i] || LAST_OUT !== (i == 3)) begin
                n_mis++;
                $display("FAIL basic_beat%0d: got valid=%b value=%h last=%b, want 1 %h %b",
                         i, VALID_OUT, VALUE_OUT, LAST_OUT, exp_a[i], (i == 3));
            end
            tick();
        end
        n_cmp++;
        if (VALID_OUT !== 1'b0 || BUSY !== 1'b0 || LAST_OUT !== 1'b0) begin
            n_mis++;
            $display("FAIL basic_idle_after: got valid=%b busy=%b last=%b, want 0 0 0",
                     VALID_OUT, BUSY, LAST_OUT);
        end
    endtask

    task automatic test_backpressure();
        int         n;
        logic       prev_stall;
        logic [7:0] prev_val;
        logic       rdy;
        n = 0;
        prev_stall = 1'b0;
        prev_val = '0;
        tick();
        VALUES_IN = VEC_A;
        READY_IN = 1'b0;
        VALIDS_IN = 4'hF;
        tick();
        VALIDS_IN = 4'h0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (VALID_OUT === 1'b1) begin
                n_cmp++;
                if (n > 3 || VALUE_OUT !== exp_a[n & 3] || LAST_OUT !== (n == 3)) begin
                    n_mis++;
                    $display("FAIL bp_order cyc%0d: got value=%h last=%b, want %h %b (beat %0d)",
                             cyc, VALUE_OUT, LAST_OUT, exp_a[n & 3], (n == 3), n);
                end
                if (prev_stall) begin
                    n_cmp++;
                    if (VALUE_OUT !== prev_val) begin
                        n_mis++;
                        $display("FAIL bp_hold cyc%0d: got %h, want %h", cyc, VALUE_OUT, prev_val);
                    end
                end
            end
            rdy = (cyc % 3 == 0);
            READY_IN = rdy;
            prev_stall = (VALID_OUT === 1'b1) && !rdy;
            prev_val = VALUE_OUT;
            if (VALID_OUT === 1'b1 && rdy) n++;
            tick();
        end
        READY_IN = 1'b1;
        n_cmp++;
        if (n != 4 || VALID_OUT !== 1'b0) begin
            n_mis++;
            $display("FAIL bp_count: got %0d transfers valid=%b, want 4 and 0", n, VALID_OUT);
        end
    endtask

    task automatic test_valids_held();
        int beats;
        int drops;
        beats = 0;
        drops = 0;
        tick();
        VALUES_IN = VEC_A;
        READY_IN = 1'b1;
        VALIDS_IN = 4'hF;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (VALID_OUT === 1'b1) beats++;
            if (DROP === 1'b1) drops++;
        end
        VALIDS_IN = 4'h0;
        tick();
        n_cmp++;
        if (beats != 4 || drops != 0) begin
            n_mis++;
            $display("FAIL held_valids: got beats=%0d drops=%0d, want 4 0", beats, drops);
        end
    endtask

    task automatic test_second_vector();
        tick();
        VALUES_IN = VEC_A;
        READY_IN = 1'b1;
        VALIDS_IN = 4'hF;
        tick();
        VALIDS_IN = 4'h0;
        n_cmp++;
        if (VALUE_OUT !== exp_a[0] || DROP !== 1'b0) begin
            n_mis++;
            $display("FAIL sv_a0: got %h drop=%b, want %h 0", VALUE_OUT, DROP, exp_a[0]);
        end
        tick();
        VALUES_IN = VEC_B;
        VALIDS_IN = 4'hF;
        n_cmp++;
        if (VALUE_OUT !== exp_a[1]) begin
            n_mis++;
            $display("FAIL sv_a1: got %h, want %h", VALUE_OUT, exp_a[1]);
        end
        tick();
        VALIDS_IN = 4'h0;
`ifdef LAYER_SERIALIZER_DBUF_EN
        n_cmp++;
        if (VALUE_OUT !== exp_a[2] || DROP !== 1'b0 || BUSY !== 1'b1) begin
            n_mis++;
            $display("FAIL sv_a2_dbuf: got %h drop=%b busy=%b, want %h 0 1", VALUE_OUT, DROP, BUSY, exp_a[2]);
        end
`else
        n_cmp++;
        if (VALUE_OUT !== exp_a[2] || DROP !== 1'b1) begin
            n_mis++;
            $display("FAIL sv_a2_drop: got %h drop=%b, want %h 1", VALUE_OUT, DROP, exp_a[2]);
        end
`endif
        tick();
        n_cmp++;
        if (VALUE_OUT !== exp_a[3] || LAST_OUT !== 1'b1 || DROP !== 1'b0) begin
            n_mis++;
            $display("FAIL sv_a3: got %h last=%b drop=%b, want %h 1 0", VALUE_OUT, LAST_OUT, DROP, exp_a[3]);
        end
        tick();
`ifdef LAYER_SERIALIZER_DBUF_EN
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (VALID_OUT !== 1'b1 || VALUE_OUT !== exp_b[i] || LAST_OUT !== (i == 3)) begin
                n_mis++;
                $display("FAIL sv_b%0d: got valid=%b value=%h last=%b, want 1 %h %b",
                         i, VALID_OUT, VALUE_OUT, LAST_OUT, exp_b[i], (i == 3));
            end
            tick();
        end
`endif
        n_cmp++;
        if (VALID_OUT !== 1'b0 || BUSY !== 1'b0) begin
            n_mis++;
            $display("FAIL sv_idle: got valid=%b busy=%b, want 0 0", VALID_OUT, BUSY);
        end
    endtask

    task automatic test_overflow();
        tick();
        VALUES_IN = VEC_B;
        READY_IN = 1'b1;
        OVERFLOW_IN = 1'b1;
        VALIDS_IN = 4'hF;
        tick();
        OVERFLOW_IN = 1'b0;
        VALIDS_IN = 4'h0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (VALID_OUT !== 1'b1 || OVERFLOW_OUT !== 1'b1 || VALUE_OUT !== exp_b[i]) begin
                n_mis++;
                $display("FAIL ovf_beat%0d: got valid=%b ovf=%b value=%h, want 1 1 %h",
                         i, VALID_OUT, OVERFLOW_OUT, VALUE_OUT, exp_b[i]);
            end
            tick();
        end
        n_cmp++;
        if (OVERFLOW_OUT !== 1'b0 || VALID_OUT !== 1'b0) begin
            n_mis++;
            $display("FAIL ovf_after: got ovf=%b valid=%b, want 0 0", OVERFLOW_OUT, VALID_OUT);
        end
    endtask

    task automatic test_reset_mid_stream();
        int beats;
        beats = 0;
        tick();
        VALUES_IN = VEC_A;
        READY_IN = 1'b1;
        OVERFLOW_IN = 1'b1;
        VALIDS_IN = 4'hF;
        tick();
        VALIDS_IN = 4'h0;
        OVERFLOW_IN = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (VALUE_OUT !== exp_a[2]) begin
            n_mis++;
            $display("FAIL mid_pre_reset: got %h, want %h", VALUE_OUT, exp_a[2]);
        end
        RSTN = 1'b0;
        #1;
        n_cmp++;
        if ({VALID_OUT, VALUE_OUT, LAST_OUT, OVERFLOW_OUT, BUSY, DROP} !== 13'd0) begin
            n_mis++;
            $display("FAIL mid_reset_outputs: got valid=%b value=%h last=%b ovf=%b busy=%b drop=%b, want all 0",
                     VALID_OUT, VALUE_OUT, LAST_OUT, OVERFLOW_OUT, BUSY, DROP);
        end
        tick();
        RSTN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (VALID_OUT !== 1'b0) beats++;
        end
        n_cmp++;
        if (beats != 0 || BUSY !== 1'b0) begin
            n_mis++;
            $display("FAIL mid_after_release: got beats=%0d busy=%b, want 0 0", beats, BUSY);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        exp_a[0] = 8'd1;  exp_a[1] = 8'd2;  exp_a[2] = 8'hFD; exp_a[3] = 8'd4;
        exp_b[0] = 8'd5;  exp_b[1] = 8'd6;  exp_b[2] = 8'd7;  exp_b[3] = 8'd8;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_valids_held();
        test_second_vector();
        test_overflow();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
